// File: rtl/legv8_multicycle_controller.sv
// legv8_multicycle_controller
// Multi-cycle sequencer for the LEGv8 tri-state datapath. Each cycle it emits a
// 40-bit control word and a 64-bit immediate. Both are registered: the word
// describing a state appears on the cycle after that state, and bits [39:37]
// carry the code of the state that produced it. mem_req, halted, fault and
// state_out decode the state register directly, so an asynchronous reset
// drops them at once.
// Optional build macro: CTRL_PERF_COUNTERS_EN adds cycle_count and instr_count.
//
// Handshake: while in FETCH or MEM, mem_req is high. The access completes in
// the cycle where mem_ready is high. Each cycle spent waiting with mem_ready low
// advances a timeout counter. The waiting cycle that brings this counter to
// MEM_TIMEOUT moves the controller to FAULT instead.
module legv8_multicycle_controller #(
    parameter logic [1:0]  PC_STEP_SEL = 2'b01,
    parameter int          MEM_TIMEOUT = 16,
    parameter logic [10:0] HALT_OPCODE = 11'b11010100010
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR_out,
    input  logic [3:0]  current_status,
    input  logic        mem_ready,
    input  logic        run,
    output logic [39:0] ControlWord,
    output logic [63:0] constant,
    output logic        mem_req,
    output logic        halted,
    output logic        fault,
    output logic [2:0]  state_out
`ifdef CTRL_PERF_COUNTERS_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_FETCH  = 3'b001;
    localparam logic [2:0] S_DECODE = 3'b010;
    localparam logic [2:0] S_EXEC   = 3'b011;
    localparam logic [2:0] S_MEM    = 3'b100;
    localparam logic [2:0] S_BRANCH = 3'b101;
    localparam logic [2:0] S_HALT   = 3'b110;
    localparam logic [2:0] S_FAULT  = 3'b111;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;

    localparam int TMO_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_nxt;

    // Instruction fields and classification
    logic [10:0] opcode;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic        is_add;
    logic        is_sub;
    logic        is_and;
    logic        is_orr;
    logic        is_rtype;
    logic        is_addi;
    logic        is_subi;
    logic        is_ldur;
    logic        is_stur;
    logic        is_b;
    logic        is_cbz;
    logic        is_halt;
    logic        is_known;
    logic [63:0] imm_alu;
    logic [63:0] imm_mem;
    logic [63:0] imm_b;
    logic [63:0] imm_cbz;

    // Only Z drives a branch decision; the other flags are intentionally ignored
    logic        unused_status;

    // Handshake helpers
    logic        waiting;
    logic        tmo_expire;
    logic [2:0]  done_state;

    // Control word fields for the cycle being computed
    logic [4:0]  cw_da;
    logic [4:0]  cw_sa;
    logic [4:0]  cw_sb;
    logic        cw_rw;
    logic        cw_mw;
    logic [1:0]  cw_size;
    logic        cw_ci;
    logic [4:0]  cw_fs;
    logic        cw_bsel;
    logic        cw_irl;
    logic        cw_sl;
    logic        cw_pcen;
    logic [1:0]  cw_pcfs;
    logic [1:0]  cw_dsel;
    logic        cw_asel;
    logic [2:0]  cw_state;
    logic [63:0] k_nxt;
    logic [39:0] cw_nxt;

    assign opcode   = IR_out[31:21];
    assign rd       = IR_out[4:0];
    assign rn       = IR_out[9:5];
    assign rm       = IR_out[20:16];
    assign is_add   = (opcode == 11'b10001011000);
    assign is_sub   = (opcode == 11'b11001011000);
    assign is_and   = (opcode == 11'b10001010000);
    assign is_orr   = (opcode == 11'b10101010000);
    assign is_rtype = is_add | is_sub | is_and | is_orr;
    assign is_addi  = (IR_out[31:22] == 10'b1001000100);
    assign is_subi  = (IR_out[31:22] == 10'b1101000100);
    assign is_ldur  = (opcode == 11'b11111000010);
    assign is_stur  = (opcode == 11'b11111000000);
    assign is_b     = (IR_out[31:26] == 6'b000101);
    assign is_cbz   = (IR_out[31:24] == 8'b10110100);
    assign is_halt  = (opcode == HALT_OPCODE);
    assign is_known = is_rtype | is_addi | is_subi | is_ldur | is_stur | is_b | is_cbz;

    // The PC has already advanced by 4 when a branch executes, hence the -4
    assign imm_alu  = {52'd0, IR_out[21:10]};
    assign imm_mem  = {{55{IR_out[20]}}, IR_out[20:12]};
    assign imm_b    = {{36{IR_out[25]}}, IR_out[25:0], 2'b00} - 64'd4;
    assign imm_cbz  = {{43{IR_out[23]}}, IR_out[23:5], 2'b00} - 64'd4;

    assign unused_status = ^current_status[3:1];

    assign waiting    = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    assign tmo_expire = waiting && (tmo_cnt == TMO_LAST);
    assign done_state = run ? S_FETCH : S_IDLE;

    assign mem_req   = (state == S_FETCH) || (state == S_MEM);
    assign halted    = (state == S_HALT);
    assign fault     = (state == S_FAULT);
    assign state_out = state;

    assign cw_nxt = {cw_state, 3'b000, cw_asel, cw_dsel, cw_pcfs, cw_pcen, cw_sl,
                     cw_irl, cw_bsel, cw_fs, cw_ci, cw_size, cw_mw, cw_rw,
                     cw_sb, cw_sa, cw_da};

    // Next-state, timeout and control word for the current state
    always_comb begin
        state_nxt = state;
        tmo_nxt   = '0;
        cw_da     = 5'd0;
        cw_sa     = 5'd0;
        cw_sb     = 5'd0;
        cw_rw     = 1'b0;
        cw_mw     = 1'b0;
        cw_size   = 2'b00;
        cw_ci     = 1'b0;
        cw_fs     = FS_AND;
        cw_bsel   = 1'b0;
        cw_irl    = 1'b0;
        cw_sl     = 1'b0;
        cw_pcen   = 1'b0;
        cw_pcfs   = 2'b00;
        cw_dsel   = 2'b00;
        cw_asel   = 1'b0;
        cw_state  = S_IDLE;
        k_nxt     = 64'd0;
        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                cw_state = S_FETCH;
                cw_size  = 2'b11;
                cw_asel  = 1'b1;
                cw_dsel  = 2'b11;
                cw_irl   = 1'b1;
                if (mem_ready) begin
                    cw_pcen   = 1'b1;
                    cw_pcfs   = PC_STEP_SEL;
                    state_nxt = S_DECODE;
                end else if (tmo_expire) begin
                    state_nxt = S_FAULT;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            S_DECODE: begin
                cw_state = S_DECODE;
                cw_size  = 2'b11;
                if (is_halt)        state_nxt = S_HALT;
                else if (!is_known) state_nxt = S_FAULT;
                else                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                cw_state  = S_EXEC;
                cw_size   = 2'b11;
                state_nxt = done_state;
                if (is_rtype) begin
                    cw_da = rd;
                    cw_sa = rn;
                    cw_sb = rm;
                    cw_rw = 1'b1;
                    cw_sl = 1'b1;
                    cw_ci = is_sub;
                    if (is_add)      cw_fs = FS_ADD;
                    else if (is_sub) cw_fs = FS_SUB;
                    else if (is_orr) cw_fs = FS_ORR;
                    else             cw_fs = FS_AND;
                end else if (is_addi || is_subi) begin
                    cw_da   = rd;
                    cw_sa   = rn;
                    cw_bsel = 1'b1;
                    cw_rw   = 1'b1;
                    cw_fs   = is_subi ? FS_SUB : FS_ADD;
                    cw_ci   = is_subi;
                    k_nxt   = imm_alu;
                end else if (is_ldur || is_stur) begin
                    cw_sa     = rn;
                    cw_bsel   = 1'b1;
                    cw_fs     = FS_ADD;
                    k_nxt     = imm_mem;
                    state_nxt = S_MEM;
                end else if (is_b) begin
                    cw_pcen = 1'b1;
                    cw_pcfs = 2'b11;
                    k_nxt   = imm_b;
                end else if (is_cbz) begin
                    // Rt + XZR sets Z exactly when Rt is zero
                    cw_sa     = rd;
                    cw_sb     = 5'd31;
                    cw_fs     = FS_ADD;
                    cw_sl     = 1'b1;
                    state_nxt = S_BRANCH;
                end
            end
            S_MEM: begin
                cw_state = S_MEM;
                cw_size  = 2'b11;
                cw_sa    = rn;
                cw_bsel  = 1'b1;
                cw_fs    = FS_ADD;
                k_nxt    = imm_mem;
                if (is_ldur) begin
                    cw_da   = rd;
                    cw_dsel = 2'b11;
                    cw_rw   = mem_ready;
                end else begin
                    cw_sb   = rd;
                    cw_dsel = 2'b01;
                    cw_mw   = 1'b1;
                end
                if (mem_ready) begin
                    state_nxt = done_state;
                end else if (tmo_expire) begin
                    state_nxt = S_FAULT;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            S_BRANCH: begin
                cw_state  = S_BRANCH;
                cw_size   = 2'b11;
                state_nxt = done_state;
                if (current_status[0]) begin
                    cw_pcen = 1'b1;
                    cw_pcfs = 2'b11;
                    k_nxt   = imm_cbz;
                end
            end
            default: begin
                // HALT and FAULT hold with an all-zero word until reset
                state_nxt = state;
            end
        endcase
    end

    // State, timeout counter and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            ControlWord <= 40'd0;
            constant    <= 64'd0;
        end else begin
            state       <= state_nxt;
            tmo_cnt     <= tmo_nxt;
            ControlWord <= cw_nxt;
            constant    <= k_nxt;
        end
    end

`ifdef CTRL_PERF_COUNTERS_EN
    logic instr_done;

    assign instr_done = ((state == S_EXEC) || (state == S_MEM) || (state == S_BRANCH)) &&
                        ((state_nxt == S_FETCH) || (state_nxt == S_IDLE));

    // Free-running activity and retired-instruction counters, wrapping at 2^32
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count <= 32'd0;
            instr_count <= 32'd0;
        end else begin
            if (state != S_IDLE) cycle_count <= cycle_count + 32'd1;
            if (instr_done)      instr_count <= instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_legv8_multicycle_controller.sv
// tb_legv8_multicycle_controller
// Directed sequences for the multicycle controller. The driver sets the inputs
// of each cycle and queues the outputs expected in that cycle. A monitor on the
// falling edge pops the queue and compares the outputs.
module tb_legv8_multicycle_controller;

    localparam int W = 110;

    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_FETCH  = 3'b001;
    localparam logic [2:0] ST_DECODE = 3'b010;
    localparam logic [2:0] ST_EXEC   = 3'b011;
    localparam logic [2:0] ST_MEM    = 3'b100;
    localparam logic [2:0] ST_BRANCH = 3'b101;
    localparam logic [2:0] ST_HALT   = 3'b110;
    localparam logic [2:0] ST_FAULT  = 3'b111;

    localparam logic [31:0] I_ADD  = 32'h8B03_0041; // ADD  X1,X2,X3
    localparam logic [31:0] I_LDUR = 32'hF840_83E2; // LDUR X2,[X31,#8]
    localparam logic [31:0] I_CBZ  = 32'hB400_0040; // CBZ  X0,#+2
    localparam logic [31:0] I_ADDI = 32'h913F_FCC5; // ADDI X5,X6,#4095
    localparam logic [31:0] I_B    = 32'h17FF_FFFF; // B    #-1
    localparam logic [31:0] I_STUR = 32'hF810_0083; // STUR X3,[X4,#-256]
    localparam logic [31:0] I_HALT = 32'hD440_0000;
    localparam logic [31:0] I_BAD  = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic [31:0] ir;
    logic [3:0]  status;
    logic        mem_ready;
    logic        run;
    logic [39:0] cw;
    logic [63:0] k;
    logic        mem_req;
    logic        halted;
    logic        fault;
    logic [2:0]  state_out;
`ifdef CTRL_PERF_COUNTERS_EN
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
    logic [63:0] perf_q[$];
`endif

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int step   = 0;

    logic [39:0] w_fetch_wait, w_fetch_go, w_decode, w_add, w_ld_exec, w_ld_wait;
    logic [39:0] w_ld_done, w_cbz_exec, w_cbz_taken, w_cbz_nt, w_addi, w_b;
    logic [39:0] w_st_exec, w_st_mem;

    legv8_multicycle_controller dut (
        .clock          (clock),
        .reset          (reset),
        .IR_out         (ir),
        .current_status (status),
        .mem_ready      (mem_ready),
        .run            (run),
        .ControlWord    (cw),
        .constant       (k),
        .mem_req        (mem_req),
        .halted         (halted),
        .fault          (fault),
        .state_out      (state_out)
`ifdef CTRL_PERF_COUNTERS_EN
        ,
        .cycle_count    (cycle_count),
        .instr_count    (instr_count)
`endif
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word with a state code and the fixed doubleword size field
    function automatic logic [39:0] base(input logic [2:0] st);
        logic [39:0] w;
        w = 40'd0;
        w[39:37] = st;
        w[18:17] = 2'b11;
        return w;
    endfunction

    // One cycle: apply inputs and queue the outputs expected during this cycle
    task automatic cyc(input logic rst, input logic r, input logic mr,
                       input logic [31:0] ins, input logic [3:0] stat,
                       input logic [2:0] est, input logic [39:0] ew,
                       input logic [63:0] ek);
        logic erq;
        logic ehl;
        logic eft;
        reset     = rst;
        run       = r;
        mem_ready = mr;
        ir        = ins;
        status    = stat;
        erq = (est == ST_FETCH) || (est == ST_MEM);
        ehl = (est == ST_HALT);
        eft = (est == ST_FAULT);
        exp_q.push_back({est, ew, ek, erq, ehl, eft});
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clock) begin
        logic [W-1:0] e;
        logic [W-1:0] got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {state_out, cw, k, mem_req, halted, fault};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL step %0d outputs: got st=%0h cw=%h k=%h req/hlt/flt=%b%b%b, expected st=%0h cw=%h k=%h req/hlt/flt=%b%b%b",
                         step, got[109:107], got[106:67], got[66:3], got[2], got[1], got[0],
                         e[109:107], e[106:67], e[66:3], e[2], e[1], e[0]);
            end
            step++;
        end
`ifdef CTRL_PERF_COUNTERS_EN
        if (perf_q.size() > 0) begin
            logic [63:0] pe;
            pe = perf_q.pop_front();
            checks++;
            if ({cycle_count, instr_count} !== pe) begin
                errors++;
                $display("FAIL perf counters: got cycles=%0d instrs=%0d, expected cycles=%0d instrs=%0d",
                         cycle_count, instr_count, pe[63:32], pe[31:0]);
            end
        end
`endif
    end

    // Stimulus
    initial begin
        w_fetch_wait = base(ST_FETCH);
        w_fetch_wait[33] = 1'b1;
        w_fetch_wait[32:31] = 2'b11;
        w_fetch_wait[26] = 1'b1;
        w_fetch_go = w_fetch_wait;
        w_fetch_go[28] = 1'b1;
        w_fetch_go[30:29] = 2'b01;
        w_decode = base(ST_DECODE);
        w_add = base(ST_EXEC);
        w_add[4:0] = 5'd1; w_add[9:5] = 5'd2; w_add[14:10] = 5'd3;
        w_add[24:20] = 5'b01000; w_add[15] = 1'b1; w_add[27] = 1'b1;
        w_ld_exec = base(ST_EXEC);
        w_ld_exec[9:5] = 5'd31; w_ld_exec[25] = 1'b1; w_ld_exec[24:20] = 5'b01000;
        w_ld_wait = base(ST_MEM);
        w_ld_wait[4:0] = 5'd2; w_ld_wait[9:5] = 5'd31; w_ld_wait[25] = 1'b1;
        w_ld_wait[24:20] = 5'b01000; w_ld_wait[32:31] = 2'b11;
        w_ld_done = w_ld_wait;
        w_ld_done[15] = 1'b1;
        w_cbz_exec = base(ST_EXEC);
        w_cbz_exec[14:10] = 5'd31; w_cbz_exec[24:20] = 5'b01000; w_cbz_exec[27] = 1'b1;
        w_cbz_taken = base(ST_BRANCH);
        w_cbz_taken[28] = 1'b1; w_cbz_taken[30:29] = 2'b11;
        w_cbz_nt = base(ST_BRANCH);
        w_addi = base(ST_EXEC);
        w_addi[4:0] = 5'd5; w_addi[9:5] = 5'd6; w_addi[25] = 1'b1;
        w_addi[24:20] = 5'b01000; w_addi[15] = 1'b1;
        w_b = base(ST_EXEC);
        w_b[28] = 1'b1; w_b[30:29] = 2'b11;
        w_st_exec = base(ST_EXEC);
        w_st_exec[9:5] = 5'd4; w_st_exec[25] = 1'b1; w_st_exec[24:20] = 5'b01000;
        w_st_mem = base(ST_MEM);
        w_st_mem[9:5] = 5'd4; w_st_mem[14:10] = 5'd3; w_st_mem[25] = 1'b1;
        w_st_mem[24:20] = 5'b01000; w_st_mem[32:31] = 2'b01; w_st_mem[16] = 1'b1;

        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = 32'd0; status = 4'd0;
        #2 reset = 1'b0;
        @(posedge clock);
        #1;

        // Reset state, then ADD with memory always ready
        cyc(0, 0, 0, I_BAD, 0, ST_IDLE, 40'd0, 64'd0);
        cyc(0, 0, 0, I_BAD, 0, ST_IDLE, 40'd0, 64'd0);
        cyc(1, 1, 1, I_ADD, 0, ST_IDLE, 40'd0, 64'd0);
        cyc(1, 1, 1, I_ADD, 0, ST_FETCH, 40'd0, 64'd0);
        cyc(1, 1, 1, I_ADD, 0, ST_DECODE, w_fetch_go, 64'd0);
        cyc(1, 1, 1, I_ADD, 0, ST_EXEC, w_decode, 64'd0);

        // LDUR with three wait cycles in MEM
        cyc(1, 1, 1, I_LDUR, 0, ST_FETCH, w_add, 64'd0);
        cyc(1, 1, 1, I_LDUR, 0, ST_DECODE, w_fetch_go, 64'd0);
        cyc(1, 1, 0, I_LDUR, 0, ST_EXEC, w_decode, 64'd0);
        cyc(1, 1, 0, I_LDUR, 0, ST_MEM, w_ld_exec, 64'd8);
        cyc(1, 1, 0, I_LDUR, 0, ST_MEM, w_ld_wait, 64'd8);
        cyc(1, 1, 0, I_LDUR, 0, ST_MEM, w_ld_wait, 64'd8);
        cyc(1, 1, 1, I_LDUR, 0, ST_MEM, w_ld_wait, 64'd8);

        // CBZ taken (Z=1)
        cyc(1, 1, 1, I_CBZ, 0, ST_FETCH, w_ld_done, 64'd8);
        cyc(1, 1, 1, I_CBZ, 0, ST_DECODE, w_fetch_go, 64'd0);
        cyc(1, 1, 1, I_CBZ, 0, ST_EXEC, w_decode, 64'd0);
        cyc(1, 1, 1, I_CBZ, 4'b0001, ST_BRANCH, w_cbz_exec, 64'd0);

        // CBZ not taken (Z=0), run dropped during the instruction
        cyc(1, 1, 1, I_CBZ, 0, ST_FETCH, w_cbz_taken, 64'd4);
        cyc(1, 1, 1, I_CBZ, 0, ST_DECODE, w_fetch_go, 64'd0);
        cyc(1, 1, 1, I_CBZ, 0, ST_EXEC, w_decode, 64'd0);
        cyc(1, 0, 1, I_CBZ, 0, ST_BRANCH, w_cbz_exec, 64'd0);
        cyc(1, 0, 1, I_CBZ, 0, ST_IDLE, w_cbz_nt, 64'd0);
        cyc(1, 0, 1, I_ADDI, 0, ST_IDLE, 40'd0, 64'd0);

        // ADDI with the largest immediate, then B backwards, then STUR
        cyc(1, 1, 1, I_ADDI, 0, ST_IDLE, 40'd0, 64'd0);
        cyc(1, 1, 1, I_ADDI, 0, ST_FETCH, 40'd0, 64'd0);
        cyc(1, 1, 1, I_ADDI, 0, ST_DECODE, w_fetch_go, 64'd0);
        cyc(1, 1, 1, I_ADDI, 0, ST_EXEC, w_decode, 64'd0);
        cyc(1, 1, 1, I_B, 0, ST_FETCH, w_addi, 64'h0000_0000_0000_0FFF);
        cyc(1, 1, 1, I_B, 0, ST_DECODE, w_fetch_go, 64'd0);
        cyc(1, 1, 1, I_B, 0, ST_EXEC, w_decode, 64'd0);
        cyc(1, 1, 1, I_STUR, 0, ST_FETCH, w_b, 64'hFFFF_FFFF_FFFF_FFF8);
        cyc(1, 1, 1, I_STUR, 0, ST_DECODE, w_fetch_go, 64'd0);
        cyc(1, 1, 1, I_STUR, 0, ST_EXEC, w_decode, 64'd0);
        cyc(1, 1, 1, I_STUR, 0, ST_MEM, w_st_exec, 64'hFFFF_FFFF_FFFF_FF00);

        // FETCH timeout: 16 waiting cycles lead to FAULT
`ifdef CTRL_PERF_COUNTERS_EN
        perf_q.push_back({32'd28, 32'd7});
`endif
        cyc(1, 1, 0, I_STUR, 0, ST_FETCH, w_st_mem, 64'hFFFF_FFFF_FFFF_FF00);
        for (int i = 0; i < 15; i++) begin
            cyc(1, 1, 0, I_STUR, 0, ST_FETCH, w_fetch_wait, 64'd0);
        end
        cyc(1, 1, 0, I_STUR, 0, ST_FAULT, w_fetch_wait, 64'd0);
        cyc(1, 1, 1, I_STUR, 0, ST_FAULT, 40'd0, 64'd0);
        cyc(1, 1, 1, I_STUR, 0, ST_FAULT, 40'd0, 64'd0);
        cyc(0, 1, 1, I_STUR, 0, ST_IDLE, 40'd0, 64'd0);

        // Reset in the middle of a FETCH wait clears mem_req immediately
        cyc(1, 1, 0, I_HALT, 0, ST_IDLE, 40'd0, 64'd0);
        cyc(1, 1, 0, I_HALT, 0, ST_FETCH, 40'd0, 64'd0);
        cyc(0, 1, 0, I_HALT, 0, ST_IDLE, 40'd0, 64'd0);
        cyc(0, 1, 0, I_HALT, 0, ST_IDLE, 40'd0, 64'd0);

        // HALT opcode
        cyc(1, 1, 1, I_HALT, 0, ST_IDLE, 40'd0, 64'd0);
        cyc(1, 1, 1, I_HALT, 0, ST_FETCH, 40'd0, 64'd0);
        cyc(1, 1, 1, I_HALT, 0, ST_DECODE, w_fetch_go, 64'd0);
        cyc(1, 1, 1, I_HALT, 0, ST_HALT, w_decode, 64'd0);
        cyc(1, 1, 1, I_HALT, 0, ST_HALT, 40'd0, 64'd0);
        cyc(1, 1, 1, I_HALT, 0, ST_HALT, 40'd0, 64'd0);
        cyc(0, 1, 1, I_HALT, 0, ST_IDLE, 40'd0, 64'd0);

        // Unknown opcode faults after DECODE
        cyc(1, 1, 1, I_BAD, 0, ST_IDLE, 40'd0, 64'd0);
        cyc(1, 1, 1, I_BAD, 0, ST_FETCH, 40'd0, 64'd0);
        cyc(1, 1, 1, I_BAD, 0, ST_DECODE, w_fetch_go, 64'd0);
        cyc(1, 1, 1, I_BAD, 0, ST_FAULT, w_decode, 64'd0);
        cyc(1, 1, 1, I_BAD, 0, ST_FAULT, 40'd0, 64'd0);

        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/legv8_multicycle_controller.md
Name: legv8_multicycle_controller

Overview:
Multi-cycle control unit that sequences the LEGv8 tri-state datapath. It emits one 40-bit control word per cycle and the immediate constant. It fetches via the PC, decodes the latched IR, runs execute/memory/branch steps, and handshakes with memory. It sits between the instruction/data memory interface and the datapath's ControlWord/constant inputs.

Parameters:
PC_STEP_SEL, 2'b01, PC_FS code for PC+4.
MEM_TIMEOUT, 16, max cycles waiting on mem_ready before fault.
HALT_OPCODE, 11'b11010100010, opcode that enters HALT.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
IR_out  in  32  instruction register contents from datapath
current_status  in  4  latched flags {V,C,N,Z}; Z = bit 0
mem_ready  in  1  memory completes the current access this cycle
run  in  1  level; controller leaves IDLE while high
ControlWord  out  40  datapath control word
constant  out  64  immediate for datapath B-mux
mem_req  out  1  memory access in progress
halted  out  1  HALT state reached
fault  out  1  illegal opcode or memory timeout
state_out  out  3  current state encoding

Behaviour:
- Reset (reset=0, async): state=IDLE; ControlWord=0, constant=0, mem_req=0, halted=0, fault=0; timeout counter=0.
- Control word fields: [4:0] DA, [9:5] SA, [14:10] SB, [15] reg_write, [16] mem_write, [18:17] size (always 2'b11), [19] carry_in, [24:20] FS, [25] B_sel (1=constant), [26] IR_load, [27] status_load, [28] PC_en, [30:29] PC_FS (00 hold, 01 +4, 10 load A, 11 PC+constant), [32:31] data_sel (00 ALU, 01 reg-to-mem, 11 mem-to-reg), [33] addr_sel (1=PC drives address), [36:34] 0, [39:37] = state_out.
- FS codes: AND 00000, ORR 00100, ADD 01000, SUB 01001 with carry_in=1.
- States: IDLE 000, FETCH 001, DECODE 010, EXEC 011, MEM 100, BRANCH 101, HALT 110, FAULT 111.
- IDLE: all-zero word except [39:37]. run=1 -> FETCH.
- FETCH: addr_sel=1, mem_req=1, data_sel=11, IR_load=1. Stays until mem_ready=1. On that cycle IR loads and PC_en=1 with PC_FS=PC_STEP_SEL, then DECODE. Timeout counter increments each waiting cycle; reaching MEM_TIMEOUT -> FAULT.
- DECODE: one cycle, no writes; classifies IR_out[31:21]. HALT_OPCODE -> HALT; unknown -> FAULT.
- EXEC, R-type ADD/SUB/AND/ORR (10001011000/11001011000/10001010000/10101010000): DA=Rd, SA=Rn, SB=Rm, reg_write=1, status_load=1 -> FETCH.
- EXEC, ADDI/SUBI (IR[31:22]=1001000100/1101000100): constant=zero-extended IR[21:10], B_sel=1, reg_write=1 -> FETCH.
- EXEC, LDUR/STUR (11111000010/11111000000): constant=sign-extended IR[20:12] -> MEM.
- MEM: ALU computes Rn+constant onto address, mem_req=1. LDUR: data_sel=11, reg_write=1 on the mem_ready cycle only. STUR: SB=Rt, data_sel=01, mem_write=1 while waiting. Same timeout rule as FETCH. -> FETCH.
- B (IR[31:26]=000101): constant=sign-extended IR[25:0]<<2 minus 4. PC_en=1, PC_FS=11 in EXEC -> FETCH.
- CBZ (IR[31:24]=10110100): EXEC computes Rt+R31 with status_load=1 -> BRANCH. BRANCH: if current_status[0]=1, PC_en=1, PC_FS=11, constant=sign-extended IR[23:5]<<2 minus 4; else no write. -> FETCH.
- Control word and constant are registered (Moore), valid one cycle after state entry.
- HALT: halted=1, zero word; exit only by reset. FAULT: fault=1, zero word; exit only by reset.
- run deasserted mid-instruction: the current instruction completes, then IDLE is entered instead of FETCH.
- Reset mid-access: mem_req drops immediately, with no partial register write.

Optional Feature:
CTRL_PERF_COUNTERS_EN: when defined, adds outputs cycle_count[31:0] (increments every non-IDLE cycle) and instr_count[31:0] (increments on each return to FETCH or IDLE after a completed instruction). Both reset to 0 and wrap at 2^32. When not defined, these ports and their logic do not exist.

Test Plan:
- reset=0 then 1, run=1, mem_ready=1 always -> state sequence IDLE, FETCH, DECODE; first FETCH word has bits 33,28,26 set and PC_FS=01.
- IR=ADD X1,X2,X3 (0x8B030041) -> EXEC word has DA=1, SA=2, SB=3, FS=01000, reg_write=1; back to FETCH.
- IR=LDUR X2,[X31,#8], mem_ready low 3 cycles -> MEM held 4 cycles, reg_write=1 only on the mem_ready cycle, constant=8.
- IR=CBZ X0,#+2 with Z=1, then Z=0 -> PC_FS=11 and constant=4 when taken; no PC_en when not taken.
- mem_ready held 0 for 16 cycles in FETCH -> fault=1, state 111, word 0; recovers only after reset pulse.
- IR=0xD4400000 (HALT) -> halted=1 after DECODE; with CTRL_PERF_COUNTERS_EN, instr_count matches the number of completed instructions.
